// File: rtl/ctl_trace_encoder_pkg.sv
// Shared definitions for the control-bus trace encoder: opcodes, control
// field encodings and trace record layout.
package ctl_trace_encoder_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP     = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADDI    = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB     = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND     = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR      = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLT     = 4'b0110;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b0111;
  localparam logic [OP_W-1:0] OP_LW      = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW      = 4'b1001;
  localparam logic [OP_W-1:0] OP_SWI     = 4'b1010;
  localparam logic [OP_W-1:0] OP_BEZI    = 4'b1100;
  localparam logic [OP_W-1:0] OP_BNZI    = 4'b1101;
  localparam logic [OP_W-1:0] OP_BEZR    = 4'b1110;
  localparam logic [OP_W-1:0] OP_BNZR    = 4'b1111;

  localparam logic [4:0] ALUOP_AND = 5'b00000;
  localparam logic [4:0] ALUOP_OR  = 5'b00001;
  localparam logic [4:0] ALUOP_ADD = 5'b00010;
  localparam logic [4:0] ALUOP_SUB = 5'b01110;
  localparam logic [4:0] ALUOP_SLT = 5'b01111;

  localparam logic [2:0] BROP_NONE = 3'b000;
  localparam logic [2:0] BROP_BEZI = 3'b100;
  localparam logic [2:0] BROP_BNZI = 3'b101;
  localparam logic [2:0] BROP_BEZR = 3'b110;
  localparam logic [2:0] BROP_BNZR = 3'b111;

  // Record layout: opcode in the top OP_W bits, repeat-1 in the low cnt_w bits.
  function automatic int rec_w(input int cnt_w);
    return OP_W + cnt_w;
  endfunction

  function automatic int rec_op_lsb(input int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/ctl_trace_encoder_fifo.sv
// Synchronous record FIFO with a registered head (head_data/head_valid are
// flops, valid the cycle after a write into an empty FIFO).
module trace_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign rd_ptr_n = rd_ptr + AW'(do_pop);

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) begin
      count_n = count + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_n = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      head_valid <= (count_n != '0);
      // The incoming record bypasses the array when it becomes the new head.
      if (do_push && (wr_ptr == rd_ptr_n)) begin
        head_data <= push_data;
      end else if (count_n != '0) begin
        head_data <= mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/ctl_trace_encoder.sv
// Observe-only tap on the control bus: re-encodes each control bundle to its
// opcode, run-length compresses repeats and queues records for the trace port.
module ctl_trace_encoder
  import ctl_trace_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  ctl_alusrc,
  input  logic                  ctl_memsrc,
  input  logic [4:0]            ctl_aluop,
  input  logic                  ctl_regdst,
  input  logic                  ctl_memwrite,
  input  logic                  ctl_regwrite,
  input  logic                  ctl_memtoreg,
  input  logic [2:0]            ctl_brop,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_W+CNT_W-1:0] out_data,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int REC_W = rec_w(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OP_W-1:0]  enc_op;
  logic             acc_v;
  logic             acc_v_n;
  logic [OP_W-1:0]  acc_op;
  logic [OP_W-1:0]  acc_op_n;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_cnt_n;
  logic             push;
  logic [REC_W-1:0] push_rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;

  // regdst only picks the destination field; it never separates two opcodes.
  logic unused_regdst;
  assign unused_regdst = ctl_regdst;

  // Plain case statements: an X/Z care bit matches no item and lands on ILLEGAL.
  always_comb begin
    enc_op = OP_ILLEGAL;
    case ({ctl_memwrite, ctl_regwrite, ctl_brop})
      {2'b00, BROP_NONE}: enc_op = OP_NOP;
      {2'b00, BROP_BEZI},
      {2'b00, BROP_BNZI},
      {2'b00, BROP_BEZR},
      {2'b00, BROP_BNZR}: enc_op = {2'b11, ctl_brop[1:0]};
      {2'b10, BROP_NONE}: begin
        case (ctl_memsrc)
          1'b0:    enc_op = OP_SW;
          1'b1:    enc_op = OP_SWI;
          default: enc_op = OP_ILLEGAL;
        endcase
      end
      {2'b01, BROP_NONE}: begin
        case (ctl_memtoreg)
          1'b1: enc_op = OP_LW;
          1'b0: begin
            case ({ctl_alusrc, ctl_aluop})
              {1'b1, ALUOP_ADD}: enc_op = OP_ADDI;
              {1'b0, ALUOP_ADD}: enc_op = OP_ADD;
              {1'b0, ALUOP_SUB}: enc_op = OP_SUB;
              {1'b0, ALUOP_AND}: enc_op = OP_AND;
              {1'b0, ALUOP_OR}:  enc_op = OP_OR;
              {1'b0, ALUOP_SLT}: enc_op = OP_SLT;
              default:           enc_op = OP_ILLEGAL;
            endcase
          end
          default: enc_op = OP_ILLEGAL;
        endcase
      end
      default: enc_op = OP_ILLEGAL;
    endcase
  end

  // Flush pushes the old run first; a coincident instruction starts a new run.
  always_comb begin
    acc_v_n   = acc_v;
    acc_op_n  = acc_op;
    acc_cnt_n = acc_cnt;
    push      = 1'b0;
    push_rec  = {acc_op, acc_cnt};
    if (flush && acc_v) begin
      push    = 1'b1;
      acc_v_n = 1'b0;
    end
    if (in_valid) begin
      if (acc_v && !flush && (enc_op == acc_op) && (acc_cnt != CNT_MAX)) begin
        acc_cnt_n = acc_cnt + CNT_W'(1);
      end else begin
        push      = acc_v;
        acc_v_n   = 1'b1;
        acc_op_n  = enc_op;
        acc_cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_v   <= 1'b0;
      acc_op  <= OP_NOP;
      acc_cnt <= '0;
    end else begin
      acc_v   <= acc_v_n;
      acc_op  <= acc_op_n;
      acc_cnt <= acc_cnt_n;
    end
  end

  assign fifo_pop = out_ready && !fifo_empty;
  assign drop     = push && fifo_full && !fifo_pop;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_rec),
    .full       (fifo_full),
    .pop        (fifo_pop),
    .empty      (fifo_empty),
    .head_valid (out_valid),
    .head_data  (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctl_trace_encoder.sv
// Randomized bench for ctl_trace_encoder: a queue-based reference model is
// compared every cycle, and directed scenarios pin records to literal values.
module tb_ctl_trace_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [13:0] drv_b = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        overflow;
  logic [7:0]  drop_count;

  // bundle layout: [13] alusrc [12] memsrc [11:7] aluop [6] regdst
  //                [5] memwrite [4] regwrite [3] memtoreg [2:0] brop
  ctl_trace_encoder #(.FIFO_DEPTH(8), .CNT_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .ctl_alusrc   (drv_b[13]),
    .ctl_memsrc   (drv_b[12]),
    .ctl_aluop    (drv_b[11:7]),
    .ctl_regdst   (drv_b[6]),
    .ctl_memwrite (drv_b[5]),
    .ctl_regwrite (drv_b[4]),
    .ctl_memtoreg (drv_b[3]),
    .ctl_brop     (drv_b[2:0]),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endfunction

  // Care bits and their values for each legal opcode, i.e. the forward decode.
  function automatic void care_of(input logic [3:0] op, output logic [13:0] val,
                                  output logic [13:0] mask);
    val = '0;
    mask = '0;
    mask[5] = 1'b1;
    mask[4] = 1'b1;
    mask[2:0] = 3'b111;
    case (op)
      4'h0: ;
      4'hC, 4'hD, 4'hE, 4'hF: val[2:0] = {1'b1, op[1:0]};
      4'h9: begin val[5] = 1'b1; mask[12] = 1'b1; end
      4'hA: begin val[5] = 1'b1; val[12] = 1'b1; mask[12] = 1'b1; end
      4'h8: begin val[4] = 1'b1; val[3] = 1'b1; mask[3] = 1'b1; end
      default: begin
        val[4] = 1'b1;
        mask[3] = 1'b1;
        mask[13] = 1'b1;
        mask[11:7] = 5'b11111;
        case (op)
          4'h1: val[11:7] = 5'b00010;
          4'h2: begin val[13] = 1'b1; val[11:7] = 5'b00010; end
          4'h3: val[11:7] = 5'b01110;
          4'h4: val[11:7] = 5'b00000;
          4'h5: val[11:7] = 5'b00001;
          4'h6: val[11:7] = 5'b01111;
          default: mask = '1;
        endcase
      end
    endcase
  endfunction

  int legal_ops[14] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 12, 13, 14, 15};

  function automatic logic [3:0] model_encode(input logic [13:0] b);
    logic [13:0] v, m;
    foreach (legal_ops[i]) begin
      care_of(4'(legal_ops[i]), v, m);
      if (((b ^ v) & m) == '0) return 4'(legal_ops[i]);
    end
    return 4'h7;
  endfunction

  function automatic logic [13:0] make_bundle(input logic [3:0] op);
    logic [13:0] v, m, r;
    care_of(op, v, m);
    r = 14'($urandom);
    return v | (r & ~m);
  endfunction

  // Reference model: run-length accumulator feeding an 8-entry record queue.
  logic [15:0] mq[$];
  bit          m_acc_v = 0;
  logic [3:0]  m_op = '0;
  int          m_cnt = 0;
  bit          m_ovf = 0;
  int          m_drop = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit          popping;
    bit          have;
    logic [15:0] rec;
    logic [3:0]  op;
    if (!rst_n) begin
      mq.delete();
      m_acc_v = 0;
      m_ovf = 0;
      m_drop = 0;
    end else begin
      popping = (mq.size() > 0) && out_ready;
      have = 0;
      rec = '0;
      op = model_encode(drv_b);
      if (flush && m_acc_v) begin
        rec = {m_op, m_cnt[11:0]};
        have = 1;
        m_acc_v = 0;
      end
      if (in_valid) begin
        if (m_acc_v && op == m_op && m_cnt < 4095) m_cnt++;
        else begin
          if (m_acc_v) begin rec = {m_op, m_cnt[11:0]}; have = 1; end
          m_acc_v = 1;
          m_op = op;
          m_cnt = 0;
        end
      end
      if (popping) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < 8) mq.push_back(rec);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  end

  logic [15:0] captured[$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) captured.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [13:0] b, input bit fl);
    in_valid = v;
    drv_b = b;
    flush = fl;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send(input logic [3:0] op);
    drive(1'b1, make_bundle(op), 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 14'(($urandom)), 1'b1);
  endtask

  logic [15:0] exp_q[$];

  task automatic expect_records(input string nm);
    for (int i = 0; i < 60 && captured.size() < exp_q.size(); i++) tick();
    for (int i = 0; i < 3; i++) tick();
    chk({nm, "_count"}, 32'(captured.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < captured.size()) chk(nm, 32'(captured[i]), 32'(exp_q[i]));
    end
    captured.delete();
    exp_q.delete();
  endtask

  task automatic random_phase(input int cycles);
    logic [3:0]  cur;
    logic [13:0] b;
    cur = 4'h1;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(3) == 0) cur = 4'(legal_ops[$urandom_range(13)]);
      b = ($urandom_range(7) == 0) ? 14'($urandom) : make_bundle(cur);
      out_ready = ($urandom_range(3) != 0);
      drive($urandom_range(3) != 0, b, $urandom_range(15) == 0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // three ADDs then SUB; flush emits the SUB run
    repeat (3) send(4'h1);
    send(4'h3);
    do_flush();
    exp_q.push_back(16'h1002);
    exp_q.push_back(16'h3000);
    expect_records("add_sub");

    // regwrite and memwrite together is not a legal bundle
    drive(1'b1, make_bundle(4'h1) | 14'h0020, 1'b0);
    do_flush();
    send(4'hA);
    send(4'hF);
    do_flush();
    exp_q.push_back(16'h7000);
    exp_q.push_back(16'hA000);
    exp_q.push_back(16'hF000);
    expect_records("illegal_swi_bnzr");

    // count field saturates after 4096 repeats
    repeat (4097) send(4'h0);
    do_flush();
    exp_q.push_back(16'h0FFF);
    exp_q.push_back(16'h0000);
    expect_records("nop_4097");

    // consumer stalled: 9 records pushed, 8 fit, one dropped
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 4'h1 : 4'h4);
    @(negedge clk);
    chk("ovf_after_stall", 32'(overflow), 32'd1);
    chk("drop_after_stall", 32'(drop_count), 32'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 16'h1000 : 16'h4000);
    expect_records("stall_drain");
    do_flush();
    exp_q.push_back(16'h4000);
    expect_records("stall_tail");

    // flush with a coincident LW
    send(4'h5);
    send(4'h5);
    drive(1'b1, make_bundle(4'h8), 1'b1);
    do_flush();
    exp_q.push_back(16'h5001);
    exp_q.push_back(16'h8000);
    expect_records("flush_and_lw");

    random_phase(2000);
    do_flush();
    repeat (20) tick();
    captured.delete();

    // drop_count saturates at 255
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 4'h6 : 4'h2);
    @(negedge clk);
    chk("drop_saturated", 32'(drop_count), 32'd255);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    tick();

    // reset in the middle of a stream
    out_ready = 1'b1;
    in_valid = 1'b1;
    drv_b = make_bundle(4'h3);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    captured.delete();
    tick();
    do_flush();
    repeat (5) tick();
    chk("post_reset_flush_records", 32'(captured.size()), 32'd0);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);

    random_phase(1500);
    do_flush();
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
